// File: rtl/clk_en_div.sv
// clk_en_div: multi-channel clock-enable divider.
// Each channel makes a one-cycle strobe and a 50% phase flag in the clk domain.
// On every strobe the channel also captures the shared free-running counter.
// Downstream logic stays on clk and qualifies on stb_o/phase_o, so no divided
// clock nets are created.

module clk_en_div #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*DIV_W-1:0]   div_i,
  input  logic [NUM_CH-1:0]         en_i,
  input  logic                      sync_i,
  output logic [CNT_W-1:0]          cnt_o,
  output logic [NUM_CH-1:0]         stb_o,
  output logic [NUM_CH-1:0]         phase_o,
  output logic [NUM_CH*CNT_W-1:0]   samp_o
);

  logic [CNT_W-1:0] cnt_q;

  // Shared free-running cycle counter; wraps naturally, ignores enable and sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_W-1:0] div_raw;
    logic [DIV_W-1:0] div_lim;
    logic [DIV_W-1:0] dcnt_q;
    logic             term;
    logic             stb_q;
    logic             phase_q;
    logic [CNT_W-1:0] samp_q;

    // Terminal test against div_eff-1, where a zero ratio behaves as ratio 1.
    // A greater-or-equal compare lets a shrinking ratio fire on the next edge
    // rather than wrapping the count all the way around.
    always_comb begin
      div_raw = div_i[k*DIV_W +: DIV_W];
      div_lim = (div_raw == '0) ? '0 : (div_raw - DIV_W'(1));
      term    = (dcnt_q >= div_lim);
    end

    // Channel state: sync beats disable, disable beats a terminal strobe.
    // The capture takes the pre-edge counter, i.e. the same-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt_q  <= '0;
        stb_q   <= 1'b0;
        phase_q <= 1'b0;
        samp_q  <= '0;
      end else if (sync_i) begin
        dcnt_q  <= '0;
        stb_q   <= 1'b0;
        phase_q <= 1'b0;
      end else if (!en_i[k]) begin
        stb_q   <= 1'b0;
      end else if (term) begin
        dcnt_q  <= '0;
        stb_q   <= 1'b1;
        phase_q <= ~phase_q;
        samp_q  <= cnt_q;
      end else begin
        dcnt_q  <= dcnt_q + DIV_W'(1);
        stb_q   <= 1'b0;
      end
    end

    assign stb_o[k]                 = stb_q;
    assign phase_o[k]               = phase_q;
    assign samp_o[k*CNT_W +: CNT_W] = samp_q;
  end

endmodule

// File: doc/clk_en_div.md
Name: clk_en_div

Overview:
Multi-channel clock-enable divider. It replaces derived or divided clocks with per-channel one-cycle strobes and phase flags, all generated in the single `clk` domain. On each strobe a channel also samples a shared free-running counter. All capture happens on the same edge as strobe generation, so the delayed-derived-clock sampling race cannot occur. Downstream logic runs on `clk` and qualifies on `stb_o`/`phase_o` instead of clocking on a divided net.

Parameters:
- NUM_CH, 2, number of independent divider channels.
- DIV_W, 8, width of each channel's divide-ratio field.
- CNT_W, 32, width of the shared free-running counter and of each sample.

Ports:
- clk  input  1  sole clock; all state updates on its posedge.
- rst_n  input  1  asynchronous active-low reset.
- div_i  input  NUM_CH*DIV_W  per-channel divide ratio. Channel k occupies bits [k*DIV_W +: DIV_W].
- en_i  input  NUM_CH  per-channel run enable.
- sync_i  input  1  synchronous realign of all channels.
- cnt_o  output  CNT_W  free-running cycle counter.
- stb_o  output  NUM_CH  one-cycle strobe per channel.
- phase_o  output  NUM_CH  divided "clock" as data; toggles on each strobe.
- samp_o  output  NUM_CH*CNT_W  per-channel cnt_o capture. Channel k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n low, async assert): cnt_o=0; per channel dcnt=0, stb_o=0, phase_o=0, samp_o=0. Deassertion is synchronised externally; the first active edge follows release.
- cnt_o: +1 every posedge; wraps 2^CNT_W-1 -> 0. Unaffected by en_i and sync_i.
- Effective ratio: div_eff = (div_i==0) ? 1 : div_i. Terminal condition: term = (dcnt >= div_eff-1).
- Per channel, at each posedge, in priority order:
  1. sync_i=1: dcnt<=0, stb_o<=0, phase_o<=0. samp_o holds. Sync beats a coincident terminal.
  2. en_i=0: dcnt holds, stb_o<=0, phase_o and samp_o hold.
  3. en_i=1 and term: dcnt<=0, stb_o<=1, phase_o<=~phase_o, samp_o<=cnt_o. The captured value is pre-edge, i.e. the same-edge value.
  4. en_i=1 and not term: dcnt<=dcnt+1, stb_o<=0.
- Strobe spacing and phase:
  - Strobe period = div_eff cycles; phase_o period = 2*div_eff cycles at 50% duty.
  - div_eff=1 gives stb_o continuously high and phase_o toggling every cycle.
- Invariant: whenever stb_o[k]=1, samp_o[k] == cnt_o-1 (mod 2^CNT_W).
- div_i change mid-count: takes effect immediately; no shadow register.
  - If the new div_eff-1 <= dcnt, the channel strobes on the next enabled edge (>= compare, no wrap-through).
- Re-enable after en_i=0: counting resumes from the held dcnt. No phase reset.
- Channels are fully independent except for shared cnt_o and sync_i.
- All outputs are registered; no combinational input-to-output path.
- Reset mid-operation: immediate clear of all state. After release, behaviour is identical to a cold start.

Test Plan:
- Reset check: hold rst_n low with random inputs -> cnt_o=0, stb_o=0, phase_o=0, samp_o=0. Assert rst_n asynchronously between edges -> outputs clear without waiting for an edge.
- Basic divide: div=4, en=1, release reset at edge 0 ->
  - stb_o high only after edges 4, 8, 12 (cnt_o = 4, 8, 12);
  - samp_o = 3, 7, 11;
  - phase_o = 1 after edge 4, 0 after edge 8.
- Edge ratios: div=0 and div=1 -> stb_o stays 1 and phase_o toggles every cycle. div=255 -> strobe every 255 cycles; samp_o equals cnt_o-1 at each strobe.
- Mid-count change: div=8 at dcnt=5, change div to 3 -> strobe on the next edge, then every 3 cycles. Change div 3->10 at dcnt=1 -> next strobe 9 edges later.
- Gating and sync:
  - div=4: drop en_i for 5 cycles at dcnt=2 -> strobe delayed exactly 5 cycles.
  - Pulse sync_i on a terminal edge -> no strobe, phase_o=0, next strobe 4 edges later.
- Counter wrap, multi-channel: CNT_W=4, ch0 div=3, ch1 div=5 ->
  - cnt_o wraps 15->0;
  - samp_o == cnt_o-1 mod 16 on every strobe;
  - channels strobe independently, with coincident strobes every 15 cycles.
